// File: rtl/tx_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_sched_pkg
//  Description : Shared types and constants for the tx_sched UART scheduler.
//                The scheduler state encoding, default sizes and the
//                requester-id width helper live here.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_sched_pkg;

    localparam int C_DEF_WIDTH   = 8;
    localparam int C_DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    // Width of a requester index; at least one bit so single-entry ids stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_sched_if
//  Description : Bundle between the producer blocks / UART serializer (master
//                side) and the tx_sched round-robin scheduler (slave side).
//  Revision    : 1.0  initial release
// ============================================================================
interface tx_sched_if import tx_sched_pkg::*; #(
    parameter int N     = 4,
    parameter int WIDTH = C_DEF_WIDTH
) ();

    localparam int C_IDW = id_width(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       grant;
    logic [N-1:0]       done;
    logic [N-1:0]       err;
    logic               tx_start;
    logic [WIDTH-1:0]   tx_pi;
    logic               tx_busy;
    logic               sched_busy;
    logic [C_IDW-1:0]   cur_id;

    // Producers and serializer
    modport master (
        output req, req_data, tx_busy,
        input  grant, done, err, tx_start, tx_pi, sched_busy, cur_id
    );

    // Scheduler
    modport slave (
        input  req, req_data, tx_busy,
        output grant, done, err, tx_start, tx_pi, sched_busy, cur_id
    );

endinterface
`default_nettype wire

// File: rtl/tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Search starts at last+1 and
//                wraps modulo N; returns a one-hot winner, its index and a
//                valid flag. Reusable for any shared-resource controller.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter import tx_sched_pkg::*; #(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  wire [N-1:0]   req,
    input  wire [IDW-1:0] last,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] winner_id,
    output logic           valid
);

    logic [IDW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the requester right
    // after last overwrites any earlier hit and ends up the winner.
    always_comb begin
        winner    = '0;
        winner_id = '0;
        valid     = 1'b0;
        w_idx     = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IDW'((int'(last) + k) % N);
            if (req[w_idx]) begin
                winner        = '0;
                winner[w_idx] = 1'b1;
                winner_id     = w_idx;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tx_sched
//  Description : Round-robin scheduler sharing one UART serializer between N
//                byte requesters. Captures one byte per grant, launches it
//                with tx_start until tx_busy rises, then waits for the frame
//                to finish before serving anyone else.
//                Optional macro TX_SCHED_TIMEOUT_EN: abandon a launch that
//                sees no tx_busy within TIMEOUT en-cycles and pulse err.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_sched import tx_sched_pkg::*; #(
    parameter int N       = 4,
    parameter int WIDTH   = C_DEF_WIDTH,
    parameter int TIMEOUT = C_DEF_TIMEOUT
) (
    input wire clk,
    input wire rst_n,
    input wire en,
    tx_sched_if.slave bus
);

    localparam int C_IDW = id_width(N);

    // Supported range: 2..8 requesters and a timeout of at least one cycle.
    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_range
    end

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic [C_IDW-1:0] r_last;
    logic [C_IDW-1:0] r_cur;

    logic [N-1:0]     w_win;
    logic [C_IDW-1:0] w_win_id;
    logic             w_win_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic [N-1:0]     w_cur_onehot;
    logic             w_run;
    logic             w_grant_fire;
    logic             w_done_fire;
    logic             w_err_fire;
    logic             w_tmo_hit;

    // Reset also gates the pulses so nothing fires while rst_n is low.
    assign w_run = en & rst_n;

    rr_arbiter #(
        .N   (N),
        .IDW (C_IDW)
    ) u_arb (
        .req       (bus.req),
        .last      (r_last),
        .winner    (w_win),
        .winner_id (w_win_id),
        .valid     (w_win_valid)
    );

    // Select the winner's byte from the flat request bus.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win[i]) begin
                w_sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot form of the requester being served, for done/err.
    always_comb begin
        w_cur_onehot        = '0;
        w_cur_onehot[r_cur] = 1'b1;
    end

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT + 1);
    logic [C_TMO_W-1:0] r_tmo;

    assign w_tmo_hit = (r_tmo == C_TMO_W'(TIMEOUT - 1));

    // Count en-cycles spent in LAUNCH without tx_busy; cleared on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (en) begin
            if (r_state == ST_LAUNCH && !bus.tx_busy && !w_tmo_hit) begin
                r_tmo <= r_tmo + C_TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end
`else
    // Without the feature a launch waits for tx_busy indefinitely.
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and event decode; pulses only on en-qualified cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_done_fire  = 1'b0;
        w_err_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // tx_busy is checked too: a serializer left running by a
                // scheduler reset must finish before the next launch.
                if (w_run && w_win_valid && !bus.tx_busy) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (w_run) begin
                    if (bus.tx_busy) begin
                        w_state_nxt = ST_WAIT_DONE;
                    end else if (w_tmo_hit) begin
                        w_err_fire  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (w_run && !bus.tx_busy) begin
                    w_done_fire = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, hold register and pointers; all frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_last  <= C_IDW'(N - 1);
            r_cur   <= '0;
        end else if (en) begin
            r_state <= w_state_nxt;
            if (w_grant_fire) begin
                r_hold <= w_sel_data;
                r_cur  <= w_win_id;
            end
            if (w_done_fire || w_err_fire) begin
                r_last <= r_cur;
            end
        end
    end

    assign bus.grant      = w_grant_fire ? w_win : '0;
    assign bus.done       = w_done_fire ? w_cur_onehot : '0;
    assign bus.err        = w_err_fire ? w_cur_onehot : '0;
    assign bus.tx_start   = (r_state == ST_LAUNCH);
    assign bus.tx_pi      = r_hold;
    assign bus.sched_busy = (r_state != ST_IDLE);
    assign bus.cur_id     = r_cur;

endmodule
`default_nettype wire
